// File: rtl/adpll_step_stimulus.sv
`default_nettype none
// ============================================================================
// Module   : adpll_step_stimulus
// Purpose  : Frequency-step reference generator with settling/lock measurement
//            for ADPLL loop-gain characterisation. Optional macro:
//            ADPLL_STEP_PEAK_EN enables peak |error| tracking.
// Revision : 1.0 - initial release
// ============================================================================
module adpll_step_stimulus #(
  parameter int unsigned      WIDTH      = 12,
  parameter logic [WIDTH-1:0] K_LOW      = 12'd36,
  parameter logic [WIDTH-1:0] K_HIGH     = 12'd40,
  parameter int unsigned      DWELL      = 2**20,
  parameter int unsigned      ERR_WIDTH  = 8,
  parameter int unsigned      LOCK_TOL   = 2,
  parameter int unsigned      LOCK_COUNT = 16
) (
  input  logic                        fpga_clk_i,
  input  logic                        reset_i,
  input  logic                        enable_i,
  input  logic signed [ERR_WIDTH-1:0] error_i,
  output logic                        ref_clk_o,
  output logic                        step_o,
  output logic                        lock_o,
  output logic                        meas_valid_o,
  output logic [23:0]                 settle_cycles_o,
  output logic [ERR_WIDTH-1:0]        peak_err_o
);

  localparam int unsigned C_DWELL_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned C_CONSEC_W = $clog2(LOCK_COUNT + 1);

  localparam logic [C_DWELL_W-1:0]  C_DWELL_LAST = C_DWELL_W'(DWELL - 1);
  localparam logic [C_CONSEC_W-1:0] C_CONSEC_MAX = C_CONSEC_W'(LOCK_COUNT - 1);
  localparam logic [23:0]           C_SETTLE_MAX = 24'hFFFFFE;
  localparam logic [23:0]           C_TIMEOUT    = 24'hFFFFFF;
  localparam logic [ERR_WIDTH-1:0]  C_ERR_MIN    = {1'b1, {(ERR_WIDTH-1){1'b0}}};
  localparam logic [ERR_WIDTH-1:0]  C_ERR_MAX    = {1'b0, {(ERR_WIDTH-1){1'b1}}};
  localparam logic [ERR_WIDTH-1:0]  C_LOCK_TOL   = ERR_WIDTH'(LOCK_TOL);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t                r_state;
  logic [WIDTH-1:0]      r_acc;
  logic                  r_msb_d;
  logic [C_DWELL_W-1:0]  r_dwell;
  logic [23:0]           r_settle;
  logic [C_CONSEC_W-1:0] r_consec;

  logic                  w_rise;
  logic                  w_dwell_wrap;
  logic                  w_step_evt;
  logic [ERR_WIDTH-1:0]  w_abs;
  logic                  w_in_tol;
  logic                  w_lock_hit;

  assign ref_clk_o    = r_acc[WIDTH-1];
  assign w_rise       = ref_clk_o & ~r_msb_d;
  assign w_dwell_wrap = (r_dwell == C_DWELL_LAST);
  // Leaving IDLE counts as a step event so every run starts a fresh window.
  assign w_step_evt   = enable_i & ((r_state == S_IDLE) | w_dwell_wrap);

  always_comb begin
    w_abs = $unsigned(error_i);
    if (error_i[ERR_WIDTH-1]) begin
      if ($unsigned(error_i) == C_ERR_MIN) w_abs = C_ERR_MAX;
      else                                 w_abs = $unsigned(-error_i);
    end
  end

  assign w_in_tol   = (w_abs <= C_LOCK_TOL);
  assign w_lock_hit = w_rise & w_in_tol & (r_consec == C_CONSEC_MAX);

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state         <= S_IDLE;
      r_acc           <= '0;
      r_msb_d         <= 1'b0;
      r_dwell         <= '0;
      r_settle        <= '0;
      r_consec        <= '0;
      step_o          <= 1'b0;
      lock_o          <= 1'b0;
      meas_valid_o    <= 1'b0;
      settle_cycles_o <= '0;
    end else begin
      meas_valid_o <= 1'b0;
      r_msb_d      <= ref_clk_o;
      if (!enable_i) begin
        r_dwell <= '0;
        step_o  <= 1'b0;
        r_state <= S_IDLE;
      end else begin
        r_acc <= r_acc + (step_o ? K_HIGH : K_LOW);
        if (w_dwell_wrap) begin
          r_dwell <= '0;
          step_o  <= ~step_o;
        end else begin
          r_dwell <= r_dwell + 1'b1;
        end

        if (w_step_evt) begin
          if (r_state == S_SETTLE) begin
            meas_valid_o    <= 1'b1;
            settle_cycles_o <= C_TIMEOUT;
          end
          r_state  <= S_SETTLE;
          r_settle <= '0;
          r_consec <= '0;
          lock_o   <= 1'b0;
        end else if (r_state == S_SETTLE) begin
          if (r_settle != C_SETTLE_MAX) r_settle <= r_settle + 24'd1;
          if (w_rise) r_consec <= w_in_tol ? r_consec + 1'b1 : '0;
          if (w_lock_hit) begin
            r_state         <= S_LOCKED;
            settle_cycles_o <= r_settle;
            lock_o          <= 1'b1;
            meas_valid_o    <= 1'b1;
          end
        end
      end
    end
  end

`ifdef ADPLL_STEP_PEAK_EN
  logic [ERR_WIDTH-1:0] r_peak;
  logic [ERR_WIDTH-1:0] w_peak_next;

  assign w_peak_next = (w_rise && (w_abs > r_peak)) ? w_abs : r_peak;

  // A timeout reports the peak accumulated before this cycle's sample.
  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_peak     <= '0;
      peak_err_o <= '0;
    end else if (w_step_evt) begin
      if (r_state == S_SETTLE) peak_err_o <= r_peak;
      r_peak <= '0;
    end else if (enable_i && (r_state == S_SETTLE)) begin
      r_peak <= w_peak_next;
      if (w_lock_hit) peak_err_o <= w_peak_next;
    end
  end
`else
  assign peak_err_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adpll_step_stimulus.sv
`default_nettype none
// ============================================================================
// Module   : tb_adpll_step_stimulus
// Purpose  : Self-checking bench for adpll_step_stimulus against a window /
//            sample-history model, plus hand-computed directed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adpll_step_stimulus;

  localparam int WIDTH      = 12;
  localparam int K_LOW      = 36;
  localparam int K_HIGH     = 40;
  localparam int DWELL      = 4000;
  localparam int LOCK_TOL   = 2;
  localparam int LOCK_COUNT = 16;

  logic              clk = 1'b0;
  logic              clk_run = 1'b0;
  logic              reset_i = 1'b0;
  logic              enable_i = 1'b0;
  logic signed [7:0] error_i = '0;
  logic              ref_clk_o, step_o, lock_o, meas_valid_o;
  logic [23:0]       settle_cycles_o;
  logic [7:0]        peak_err_o;

  int checks = 0;
  int failures = 0;

  adpll_step_stimulus #(
    .WIDTH(WIDTH), .K_LOW(12'd36), .K_HIGH(12'd40), .DWELL(DWELL),
    .ERR_WIDTH(8), .LOCK_TOL(LOCK_TOL), .LOCK_COUNT(LOCK_COUNT)
  ) dut (
    .fpga_clk_i(clk), .reset_i(reset_i), .enable_i(enable_i), .error_i(error_i),
    .ref_clk_o(ref_clk_o), .step_o(step_o), .lock_o(lock_o),
    .meas_valid_o(meas_valid_o), .settle_cycles_o(settle_cycles_o),
    .peak_err_o(peak_err_o)
  );

  always #5 clk = clk_run ? ~clk : clk;

  // ---------------- reference model: windows of sampled |error| ----------
  int  m_acc, m_dwell, m_state, m_cyc, m_win, m_settle, m_peak;
  bit  m_ref, m_ref_d, m_step, m_lock, m_valid;
  int  q[$];

  function automatic int abs_sat(input logic signed [7:0] e);
    int v;
    v = int'(e);
    if (v == -128) return 127;
    return (v < 0) ? -v : v;
  endfunction

  function automatic int peak_of_q();
    int p;
    p = 0;
`ifdef ADPLL_STEP_PEAK_EN
    foreach (q[i]) if (q[i] > p) p = q[i];
`endif
    return p;
  endfunction

  function automatic bit tail_locked();
    if (q.size() < LOCK_COUNT) return 1'b0;
    for (int i = q.size() - LOCK_COUNT; i < q.size(); i++)
      if (q[i] > LOCK_TOL) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge reset_i) begin
    bit rise, evt;
    if (reset_i) begin
      m_acc = 0; m_dwell = 0; m_state = 0; m_cyc = 0; m_win = 0;
      m_settle = 0; m_peak = 0; m_ref = 0; m_ref_d = 0; m_step = 0;
      m_lock = 0; m_valid = 0;
      q.delete();
    end else begin
      rise    = m_ref && !m_ref_d;
      m_cyc   = m_cyc + 1;
      m_valid = 0;
      m_ref_d = m_ref;
      if (!enable_i) begin
        m_dwell = 0; m_step = 0; m_state = 0;
      end else begin
        evt   = (m_state == 0) || (m_dwell == DWELL - 1);
        m_acc = (m_acc + (m_step ? K_HIGH : K_LOW)) % (1 << WIDTH);
        if (m_dwell == DWELL - 1) begin
          m_dwell = 0;
          m_step  = !m_step;
        end else begin
          m_dwell = m_dwell + 1;
        end
        if (evt) begin
          if (m_state == 1) begin
            m_valid = 1; m_settle = 24'hFFFFFF; m_peak = peak_of_q();
          end
          m_state = 1; m_win = m_cyc; m_lock = 0;
          q.delete();
        end else if (m_state == 1 && rise) begin
          q.push_back(abs_sat(error_i));
          if (tail_locked()) begin
            m_state  = 2; m_lock = 1; m_valid = 1;
            m_settle = m_cyc - m_win - 1;
            if (m_settle > 24'hFFFFFE) m_settle = 24'hFFFFFE;
            m_peak   = peak_of_q();
          end
        end
      end
      m_ref = ((m_acc >> (WIDTH - 1)) & 1) != 0;
    end
  end

  // ---------------- checking helpers ----------------------------------
  task automatic compare_model();
    checks++;
    if (ref_clk_o !== m_ref || step_o !== m_step || lock_o !== m_lock ||
        meas_valid_o !== m_valid || settle_cycles_o !== 24'(m_settle) ||
        peak_err_o !== 8'(m_peak)) begin
      failures++;
      $display("FAIL model t=%0t got ref=%b step=%b lock=%b mv=%b settle=%0d peak=%0d want ref=%b step=%b lock=%b mv=%b settle=%0d peak=%0d",
               $time, ref_clk_o, step_o, lock_o, meas_valid_o, settle_cycles_o, peak_err_o,
               m_ref, m_step, m_lock, m_valid, m_settle, m_peak);
    end
  endtask

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  int err_mode = 0;   // 0 const, 1 -128 on first sample, 2 pattern with 3, 3 random
  int err_const = 0;

  task automatic drive_err();
    case (err_mode)
      0: error_i = 8'(err_const);
      1: error_i = (q.size() == 0) ? 8'sh80 : 8'sh00;
      2: error_i = (q.size() == 15) ? 8'sd3 : 8'sd0;
      default: begin
        if ($urandom_range(0, 19) != 0) error_i = 8'(int'($urandom_range(0, 4)) - 2);
        else                            error_i = 8'(int'($urandom_range(0, 255)) - 128);
      end
    endcase
  endtask

  task automatic tick();
    drive_err();
    @(negedge clk);
    compare_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    enable_i = 1'b0;
    #2 reset_i = 1'b1;
    #1 compare_model();
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  task automatic wait_meas(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!meas_valid_o && n < budget);
    if (!meas_valid_o) begin
      checks++;
      failures++;
      $display("FAIL wait_meas no pulse within %0d cycles", budget);
    end
  endtask

  int exp_pk10, exp_pk127, exp_pk3;

  initial begin
    int n, extra;
`ifdef ADPLL_STEP_PEAK_EN
    exp_pk10 = 10; exp_pk127 = 127; exp_pk3 = 3;
`else
    exp_pk10 = 0;  exp_pk127 = 0;   exp_pk3 = 0;
`endif
    // Reset with the clock stopped: outputs must clear asynchronously.
    #10 reset_i = 1'b1;
    #1;
    check_eq("reset_async", int'({ref_clk_o, step_o, lock_o, meas_valid_o}) +
             int'(settle_cycles_o) + int'(peak_err_o), 0);
    compare_model();
    #10 reset_i = 1'b0;
    clk_run = 1'b1;
    repeat (5) tick();
    check_eq("idle_ref_low", int'(ref_clk_o), 0);

    // Zero error: lock at the 16th rising edge, step at cycle 4000.
    err_mode = 0; err_const = 0;
    enable_i = 1'b1;
    wait_meas(3000, n);
    check_eq("lock0_cycle", n, 1765);
    check_eq("lock0_settle", int'(settle_cycles_o), 1763);
    check_eq("lock0_peak", int'(peak_err_o), 0);
    check_eq("lock0_lock", int'(lock_o), 1);
    extra = 0;
    do begin
      tick();
      n++;
      if (meas_valid_o) extra++;
    end while (!step_o && n < 4100);
    check_eq("step_at_dwell", n, 4000);
    check_eq("step_lock_drop", int'(lock_o), 0);
    check_eq("no_meas_after_lock", extra, 0);

    // Constant +10: timeout at the step.
    do_reset();
    err_mode = 0; err_const = 10;
    enable_i = 1'b1;
    wait_meas(4100, n);
    check_eq("timeout_cycle", n, 4000);
    check_eq("timeout_settle", int'(settle_cycles_o), 24'hFFFFFF);
    check_eq("timeout_peak", int'(peak_err_o), exp_pk10);
    check_eq("timeout_lock", int'(lock_o), 0);

    // One -128 sample, then zeros.
    do_reset();
    err_mode = 1;
    enable_i = 1'b1;
    wait_meas(3000, n);
    check_eq("neg_settle", int'(settle_cycles_o), 1877);
    check_eq("neg_peak", int'(peak_err_o), exp_pk127);
    check_eq("neg_lock", int'(lock_o), 1);

    // 15 zeros, a 3, then 16 zeros: lock at the 32nd edge.
    do_reset();
    err_mode = 2;
    enable_i = 1'b1;
    wait_meas(4000, n);
    check_eq("pat_cycle", n, 3585);
    check_eq("pat_settle", int'(settle_cycles_o), 3583);
    check_eq("pat_peak", int'(peak_err_o), exp_pk3);

    // Reset mid-SETTLE.
    do_reset();
    err_mode = 0; err_const = 10;
    enable_i = 1'b1;
    repeat (500) tick();
    #2 reset_i = 1'b1;
    #1;
    check_eq("reset_settle", int'({ref_clk_o, step_o, lock_o, meas_valid_o}) +
             int'(settle_cycles_o) + int'(peak_err_o), 0);
    compare_model();
    @(negedge clk);
    reset_i = 1'b0;
    enable_i = 1'b0;

    // Disable while LOCKED: measurement retained, accumulator frozen.
    do_reset();
    err_mode = 0; err_const = 0;
    enable_i = 1'b1;
    wait_meas(3000, n);
    enable_i = 1'b0;
    repeat (10) tick();
    check_eq("dis_step", int'(step_o), 0);
    check_eq("dis_ref_frozen", int'(ref_clk_o), 1);
    check_eq("dis_lock_kept", int'(lock_o), 1);
    check_eq("dis_settle_kept", int'(settle_cycles_o), 1763);

    // Randomised run with occasional enable drops and one reset.
    do_reset();
    err_mode = 3;
    enable_i = 1'b1;
    for (int i = 0; i < 30000; i++) begin
      if (i == 15000) begin
        do_reset();
        enable_i = 1'b1;
      end
      if ($urandom_range(0, 4999) == 0) begin
        enable_i = 1'b0;
        repeat ($urandom_range(1, 20)) tick();
        enable_i = 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
